// File: rtl/cache_traffic_gen.sv
// Write/read-back sweep generator standing in for the CPU on the cache request port.
// Optional request watchdog: define TRAFFIC_GEN_TIMEOUT_EN.
module cache_traffic_gen #(
    parameter int unsigned         ADDR_W         = 27,
    parameter int unsigned         DATA_W         = 32,
    parameter int unsigned         NUM_TXN        = 16,
    parameter logic [ADDR_W-1:0]   BASE_ADDR      = ADDR_W'(27'h0AAAAAA),
    parameter logic [ADDR_W-1:0]   STRIDE         = ADDR_W'(27'h0000400),
    parameter logic [DATA_W-1:0]   SEED           = DATA_W'(32'h5A5A_3C3C),
    parameter int unsigned         TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic                           start,
    input  logic                           mode,
    output logic [ADDR_W-1:0]              req_addr,
    output logic [DATA_W-1:0]              req_data,
    output logic                           req_rw,
    output logic                           req_valid,
    input  logic [DATA_W-1:0]              res_data,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [$clog2(NUM_TXN+1)-1:0]   err_count,
    output logic [ADDR_W-1:0]              first_err_addr,
    output logic                           led
);

    localparam int unsigned CNT_W = $clog2(NUM_TXN + 1);
    localparam int unsigned IDX_W = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

    if (NUM_TXN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cache_traffic_gen: NUM_TXN and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DONE
`ifdef TRAFFIC_GEN_TIMEOUT_EN
        , S_TOUT
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                mode_q, mode_d;
    logic                req_valid_q, req_valid_d;
    logic                req_rw_q, req_rw_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]    timer_q, timer_d;
`endif

    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]   pat_c;
    logic                last_c;
    logic                mismatch_c;

    // Address and pattern are pure functions of the index.
    assign addr_c     = ADDR_W'(BASE_ADDR + ADDR_W'(idx_q) * STRIDE);
    assign pat_c      = SEED ^ DATA_W'(addr_c) ^ DATA_W'({(DATA_W/2){2'(idx_q)}});
    assign last_c     = (idx_q == LAST_IDX);
    assign mismatch_c = (res_data != pat_c);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        req_valid_d = req_valid_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
`ifdef TRAFFIC_GEN_TIMEOUT_EN
            S_IDLE, S_DONE, S_TOUT: begin
`else
            S_IDLE, S_DONE: begin
`endif
                if (start) begin
                    state_d     = S_WR;
                    idx_d       = '0;
                    mode_d      = mode;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    first_err_d = '0;
                end
            end
            S_WR, S_RD: begin
                // First cycle in a state is the gap; the request issues on the next.
                if (!req_valid_q) begin
                    req_valid_d = 1'b1;
                    req_rw_d    = (state_q == S_WR);
                    req_addr_d  = addr_c;
                    req_data_d  = pat_c;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end else if (res_ready) begin
                    req_valid_d = 1'b0;
                    if (state_q == S_WR) begin
                        if (mode_q) begin
                            state_d = S_RD;
                        end else if (last_c) begin
                            state_d = S_RD;
                            idx_d   = '0;
                        end else begin
                            idx_d = IDX_W'(idx_q + 1'b1);
                        end
                    end else begin
                        if (mismatch_c) begin
                            if (err_count_q != CNT_W'(NUM_TXN)) begin
                                err_count_d = CNT_W'(err_count_q + 1'b1);
                            end
                            if (err_count_q == '0) begin
                                first_err_d = addr_c;
                            end
                        end
                        if (last_c) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = !mismatch_c && (err_count_q == '0);
                        end else begin
                            idx_d = IDX_W'(idx_q + 1'b1);
                            if (mode_q) begin
                                state_d = S_WR;
                            end
                        end
                    end
`ifdef TRAFFIC_GEN_TIMEOUT_EN
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_TOUT;
                    req_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    if (err_count_q == '0) begin
                        first_err_d = req_addr_q;
                    end
                end else begin
                    timer_d = TMR_W'(timer_q + 1'b1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_err_q <= '0;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            req_valid_q <= req_valid_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign req_addr       = req_addr_q;
    assign req_data       = req_data_q;
    assign req_rw         = req_rw_q;
    assign req_valid      = req_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign led            = pass_q;

endmodule

// File: doc/cache_traffic_gen.md
Name: cache_traffic_gen

Overview:
Parametrised, self-checking traffic generator for bring-up of the L1 cache / DRAM path on the board. It replaces hand-scripted request sequences with a configurable write/read-back sweep: writes a data pattern to NUM_TXN addresses, reads every address back through the cache, and compares each result. It sits in place of the CPU on the cpu_req/cpu_res side of the cache and drives a pass LED.

Parameters:
ADDR_W, 27, width of the cache request address
DATA_W, 32, width of the CPU-side data word
NUM_TXN, 16, number of addresses per sweep (>=1)
BASE_ADDR, 27'h0AAAAAA, first address of the sweep
STRIDE, 27'h0000400, address increment per transaction (chosen to alias cache sets and force evictions)
SEED, 32'h5A5A_3C3C, data pattern seed
TIMEOUT_CYCLES, 4096, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  single clock for all logic
RST  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; starts a sweep when idle or done
mode  in  1  0 = all writes then all reads; 1 = per-address write immediately followed by its read
req_addr  out  ADDR_W  request address to cache
req_data  out  DATA_W  request write data
req_rw  out  1  1 = write, 0 = read
req_valid  out  1  request valid
res_data  in  DATA_W  cache read data
res_ready  in  1  cache response/completion pulse
busy  out  1  sweep in progress
done  out  1  sweep finished (held until next start or reset)
pass  out  1  done and zero mismatches
err_count  out  $clog2(NUM_TXN+1)  number of read mismatches (saturates at NUM_TXN)
first_err_addr  out  ADDR_W  address of first mismatch, 0 if none
led  out  1  equals pass

Behaviour:
- Reset (RST low at posedge clk): state IDLE; req_valid=0, req_rw=0, req_addr=0, req_data=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, index=0. Reset overrides any in-flight request; a late res_ready after reset is ignored.
- Address: addr(i) = (BASE_ADDR + i*STRIDE) mod 2^ADDR_W; wrap-around is silent.
- Data: pat(i) = SEED ^ zero-extend(addr(i)) ^ {DATA_W/2 copies of 2'(i)} truncated to DATA_W; computed combinationally from index, no storage RAM.
- States: IDLE, WR, RD, DONE (plus TOUT with feature).
- IDLE/DONE: on start -> clear err_count, first_err_addr, done, pass; index=0; go WR; busy=1.
- Handshake: req_valid rises the cycle after entering WR/RD; addr/data/rw held stable while req_valid=1; transaction completes at the posedge where req_valid=1 and res_ready=1; req_valid drops for exactly one cycle after each completion before the next request. res_ready while req_valid=0 is ignored.
- mode 0: WR completes index 0..NUM_TXN-1, then index=0, go RD; RD completes 0..NUM_TXN-1, then DONE.
- mode 1: WR(i) -> RD(i) -> WR(i+1) ... ; after RD(NUM_TXN-1) go DONE.
- Compare on each RD completion: res_data != pat(index) -> err_count++ (saturating); if first mismatch, latch first_err_addr=addr(index).
- DONE: busy=0, done=1, pass=(err_count==0); outputs held. mode sampled at start only; changes mid-sweep ignored. start while busy ignored.
- Latency: sweep length = sum of cache latencies + 2 cycles per transaction minimum (1 issue, 1 gap).

Optional Feature:
TRAFFIC_GEN_TIMEOUT_EN: defined -> cycle counter reset at each request issue; if req_valid stays high TIMEOUT_CYCLES cycles without res_ready, go TOUT: req_valid=0, busy=0, done=1, pass=0, err_count unchanged, first_err_addr=current addr if no prior error; start leaves TOUT as from DONE. Undefined -> no counter, generator waits indefinitely; TOUT state absent.

Test Plan:
- Ideal cache model (1-cycle ready, perfect memory), NUM_TXN=16, mode 0 -> 16 writes then 16 reads in order, done=1, pass=1, err_count=0, led=1.
- Same, mode 1 -> requests alternate W/R per address addr(0)=0x0AAAAAA, addr(1)=0x0AAAEAA; pass=1.
- Model corrupts read of index 5 (flip bit 0) -> err_count=1, first_err_addr=BASE_ADDR+5*STRIDE=0x0AABEAA, pass=0, led=0.
- BASE_ADDR=27'h7FFFFF0, STRIDE=27'h10, NUM_TXN=4 -> addresses 0x7FFFFF0, 0x0000000, 0x0000010, 0x0000020 (wrap); pass=1.
- Assert RST low mid-RD at index 3, then release, pulse start -> all outputs at reset values, sweep restarts from index 0 and passes; stale res_ready during reset ignored.
- With TRAFFIC_GEN_TIMEOUT_EN, TIMEOUT_CYCLES=64, model never answers write 2 -> after 64 cycles req_valid=0, done=1, pass=0, first_err_addr=0x0AAB2AA.
